// File: rtl/extrema_pkg.sv
// Shared types and constants for the frame extrema tracker and its comparators.
package extrema_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Cascade seeds: with equal operands the comparator reports "equal".
    localparam logic CASC_LIN = 1'b0;
    localparam logic CASC_EIN = 1'b1;
    localparam logic CASC_GIN = 1'b0;

    typedef struct packed {
        logic [DATA_W-1:0] max;
        logic [DATA_W-1:0] min;
    } extrema_t;

endpackage

// File: rtl/eight_bit_comparator.sv
// Unsigned 8-bit magnitude comparator with cascade inputs for the equal case.
module eight_bit_comparator
    import extrema_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              lin,
    input  logic              ein,
    input  logic              gin,
    output logic              lt_c,
    output logic              eq_c,
    output logic              gt_c
);

    always_comb begin
        lt_c = 1'b0;
        eq_c = 1'b0;
        gt_c = 1'b0;
        if (a > b) begin
            gt_c = 1'b1;
        end else if (a < b) begin
            lt_c = 1'b1;
        end else begin
            lt_c = lin;
            eq_c = ein;
            gt_c = gin;
        end
    end

endmodule

// File: rtl/frame_extrema_tracker.sv
// Streams 8-bit samples and reports per-frame max, min, first-max index and beat count.
module frame_extrema_tracker
    import extrema_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_max_idx,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_t           state_q, state_d;
    extrema_t         ext_q, ext_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic accept_c;
    logic max_lt_c, max_eq_c, max_gt_c;
    logic min_lt_c, min_eq_c, min_gt_c;
    logic unused_cmp_c;

    assign in_ready = rst_n && (state_q != ST_HOLD);
    assign accept_c = in_valid && in_ready;

    eight_bit_comparator u_cmp_max (
        .a    (in_data),
        .b    (ext_q.max),
        .lin  (CASC_LIN),
        .ein  (CASC_EIN),
        .gin  (CASC_GIN),
        .lt_c (max_lt_c),
        .eq_c (max_eq_c),
        .gt_c (max_gt_c)
    );

    eight_bit_comparator u_cmp_min (
        .a    (in_data),
        .b    (ext_q.min),
        .lin  (CASC_LIN),
        .ein  (CASC_EIN),
        .gin  (CASC_GIN),
        .lt_c (min_lt_c),
        .eq_c (min_eq_c),
        .gt_c (min_gt_c)
    );

    // Only strict greater/less matter; ties keep the earlier value and index.
    assign unused_cmp_c = ^{max_lt_c, max_eq_c, min_eq_c, min_gt_c};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ext_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        idx_d   = idx_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    ext_d.max = in_data;
                    ext_d.min = in_data;
                    idx_d     = '0;
                    count_d   = CNT_W'(1);
                    ovf_d     = 1'b0;
                    state_d   = in_last ? ST_HOLD : ST_ACC;
                    valid_d   = in_last;
                end
            end
            ST_ACC: begin
                if (accept_c) begin
                    // count_q equals this beat's index until saturation pins it.
                    if (max_gt_c) begin
                        ext_d.max = in_data;
                        idx_d     = count_q;
                    end
                    if (min_lt_c) begin
                        ext_d.min = in_data;
                    end
                    if (count_q == CNT_SAT) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign out_valid   = valid_q;
    assign out_max     = ext_q.max;
    assign out_min     = ext_q.min;
    assign out_max_idx = idx_q;
    assign out_count   = count_q;
    assign out_ovf     = ovf_q;

endmodule
